// File: rtl/rr_enc_pkg.sv
// Shared defaults, FSM state encoding and helpers for the round-robin 8-to-3 encoder.
package rr_enc_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_DEF-1:0] onehot(input logic [W_DEF-1:0] idx);
    logic [N_DEF-1:0] vec;
    vec = {N_DEF{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: rotating scan from ptr (rr=1) or highest set index (rr=0).
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic         hit
);

  // Scan the candidate vector; N is a power of two so the W-bit sum wraps modulo N
  always_comb begin
    logic [W-1:0] j_s;
    idx = {W{1'b0}};
    hit = 1'b0;
    j_s = {W{1'b0}};
    if (rr) begin
      for (int i = 0; i < N; i++) begin
        j_s = ptr + W'(i);
        if (!hit && cand[j_s]) begin
          hit = 1'b1;
          idx = j_s;
        end else begin
          hit = hit;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          hit = 1'b1;
          idx = W'(i);
        end else begin
          hit = hit;
        end
      end
    end
  end

endmodule

// File: rtl/rr_encoder_8to3.sv
// Registered 8-to-3 encoder with sticky request capture and a valid/ready output handshake.
module rr_encoder_8to3
  import rr_enc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int RR = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         any
);

  localparam logic RR_EN = (RR != 0);

  state_t         state_r;
  logic [N-1:0]   pend_r;
  logic [W-1:0]   ptr_r;
  logic [W-1:0]   code_r;
  logic           valid_r;

  logic [N-1:0]   cand_s;
  logic [N-1:0]   clr_mask_s;
  logic [N-1:0]   pend_nxt_s;
  logic [W-1:0]   pick_idx_s;
  logic           pick_hit_s;

  assign cand_s = pend_r | req;
  assign any    = |cand_s;
  assign code   = code_r;
  assign valid  = valid_r;
  assign pend   = pend_r;

  rr_pick #(.N(N), .W(W)) u_pick (
    .cand (cand_s),
    .ptr  (ptr_r),
    .rr   (RR_EN),
    .idx  (pick_idx_s),
    .hit  (pick_hit_s)
  );

  // Clear the granted bit on handshake; a simultaneous request on that bit keeps it pending
  always_comb begin
    clr_mask_s = {N{1'b0}};
    if (valid_r && ready) begin
      clr_mask_s = onehot(code_r);
    end else begin
      clr_mask_s = {N{1'b0}};
    end
    pend_nxt_s = (pend_r & ~clr_mask_s) | req;
  end

  // Grant FSM with pending, pointer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      pend_r  <= {N{1'b0}};
      ptr_r   <= {W{1'b0}};
      code_r  <= {W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      case (state_r)
        IDLE: begin
          if (en && pick_hit_s) begin
            code_r  <= pick_idx_s;
            valid_r <= 1'b1;
            state_r <= HOLD;
          end else begin
            valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (ready) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
            if (RR_EN) begin
              ptr_r <= code_r + W'(1);
            end else begin
              ptr_r <= ptr_r;
            end
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
